// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between an I-cache fill engine and a D-cache.
// Round-robin between fills, single-cycle write-through priority, registered grants.
module mem_arbiter #(
  parameter int BURST_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  input  logic [15:0] dcache_addr,
  input  logic [15:0] dcache_wdata,
  input  logic        mem_data_valid,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  output logic        icache_grant,
  output logic        dcache_grant,
  output logic        icache_data_valid,
  output logic        dcache_data_valid
);

  localparam int CW = $clog2(BURST_WORDS) + 1;
  localparam logic [CW-1:0] LP_LAST = CW'(BURST_WORDS - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IFILL,
    S_DFILL,
    S_DWRITE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_last_owner, w_last_owner_nxt;  // 0 = I-cache, 1 = D-cache
  logic          w_dfill_req;
  logic          w_owner_req;
  logic          w_owner_side;

  assign w_dfill_req  = dcache_req & ~dcache_wr;
  assign w_owner_req  = (r_state == S_DFILL) ? dcache_req : icache_req;
  assign w_owner_side = (r_state == S_DFILL);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_last_owner_nxt = r_last_owner;
    unique case (r_state)
      S_IDLE: begin
        if (dcache_req && dcache_wr) begin
          w_state_nxt = S_DWRITE;
        end else if (icache_req && w_dfill_req) begin
          // Tie goes to whichever side did not own memory last.
          w_state_nxt = r_last_owner ? S_IFILL : S_DFILL;
        end else if (icache_req) begin
          w_state_nxt = S_IFILL;
        end else if (w_dfill_req) begin
          w_state_nxt = S_DFILL;
        end
      end
      S_IFILL, S_DFILL: begin
        if (!w_owner_req) begin
          w_state_nxt      = S_IDLE;
          w_count_nxt      = '0;
          w_last_owner_nxt = w_owner_side;
        end else if (mem_data_valid) begin
          if (r_count == LP_LAST) begin
            w_state_nxt      = S_IDLE;
            w_count_nxt      = '0;
            w_last_owner_nxt = w_owner_side;
          end else begin
            w_count_nxt = r_count + LP_ONE;
          end
        end
      end
      S_DWRITE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the registered state, so reset clears them immediately.
  always_comb begin
    mem_addr          = '0;
    mem_enable        = 1'b0;
    mem_wr            = 1'b0;
    mem_wdata         = '0;
    icache_grant      = 1'b0;
    dcache_grant      = 1'b0;
    icache_data_valid = 1'b0;
    dcache_data_valid = 1'b0;
    unique case (r_state)
      S_IFILL: begin
        mem_enable        = 1'b1;
        mem_addr          = icache_addr;
        icache_grant      = 1'b1;
        icache_data_valid = mem_data_valid;
      end
      S_DFILL: begin
        mem_enable        = 1'b1;
        mem_addr          = dcache_addr;
        dcache_grant      = 1'b1;
        dcache_data_valid = mem_data_valid;
      end
      S_DWRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = dcache_addr;
        mem_wdata    = dcache_wdata;
        dcache_grant = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected data beats and
// writes, plus cycle-accurate grant checks.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        icache_req;
  logic [15:0] icache_addr;
  logic        dcache_req;
  logic        dcache_wr;
  logic [15:0] dcache_addr;
  logic [15:0] dcache_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic        icache_grant;
  logic        dcache_grant;
  logic        icache_data_valid;
  logic        dcache_data_valid;

  localparam logic [1:0] K_I = 2'd0;
  localparam logic [1:0] K_D = 2'd1;
  localparam logic [1:0] K_W = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks;
  int  n_errors;

  mem_arbiter #(.BURST_WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .icache_req        (icache_req),
    .icache_addr       (icache_addr),
    .dcache_req        (dcache_req),
    .dcache_wr         (dcache_wr),
    .dcache_addr       (dcache_addr),
    .dcache_wdata      (dcache_wdata),
    .mem_data_valid    (mem_data_valid),
    .mem_addr          (mem_addr),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .mem_wdata         (mem_wdata),
    .icache_grant      (icache_grant),
    .dcache_grant      (dcache_grant),
    .icache_data_valid (icache_data_valid),
    .dcache_data_valid (dcache_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({mem_addr, mem_enable, mem_wr, mem_wdata,
                icache_grant, dcache_grant, icache_data_valid, dcache_data_valid});
  endfunction

  // Scoreboard monitor: every routed beat or write must match the queue head.
  always @(negedge clk) begin
    logic [1:0] obs_kind;
    sb_t        exp_item;
    check("grant_exclusive", 64'(icache_grant & dcache_grant), 64'd0);
    if (icache_data_valid || dcache_data_valid || mem_wr) begin
      obs_kind = mem_wr ? K_W : (dcache_data_valid ? K_D : K_I);
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'({icache_data_valid, dcache_data_valid, mem_wr}), 64'd0);
      end else begin
        exp_item = sb_q.pop_front();
        check("sb_kind", 64'(obs_kind), 64'(exp_item.kind));
        check("sb_addr", 64'(mem_addr), 64'(exp_item.addr));
        check("sb_wdata", 64'(mem_wdata), 64'(exp_item.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Consumes one cycle, checking the grant pair at mid-cycle.
  task automatic expect_grant(input string tag, input logic ig, input logic dg);
    @(negedge clk);
    check(tag, 64'({icache_grant, dcache_grant}), 64'({ig, dg}));
    cyc();
  endtask

  task automatic fill(input string tag, input logic [1:0] kind, input logic [15:0] addr,
                      input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) expect_grant(tag, kind == K_I, kind == K_D);
      mem_data_valid = 1'b1;
      sb_q.push_back('{kind: kind, addr: addr, data: 16'h0000});
      expect_grant(tag, kind == K_I, kind == K_D);
      mem_data_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    icache_req = 1'b0;
    dcache_req = 1'b0;
    dcache_wr = 1'b0;
    mem_data_valid = 1'b0;
    cyc();
    @(negedge clk);
    check("reset_outs", outs_vec(), 64'd0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    icache_req = 1'b0;
    icache_addr = '0;
    dcache_req = 1'b0;
    dcache_wr = 1'b0;
    dcache_addr = '0;
    dcache_wdata = '0;
    mem_data_valid = 1'b0;
    do_reset();

    // Lone I-fill, beats every 4 cycles.
    icache_addr = 16'h0100;
    icache_req  = 1'b1;
    expect_grant("t1_idle", 1'b0, 1'b0);
    @(negedge clk);
    check("t1_addr", 64'(mem_addr), 64'h0100);
    check("t1_enable", 64'({mem_enable, mem_wr}), 64'b10);
    cyc();
    fill("t1_fill", K_I, 16'h0100, 8, 3);
    icache_req = 1'b0;
    expect_grant("t1_done", 1'b0, 1'b0);
    @(negedge clk);
    check("t1_idle_outs", outs_vec(), 64'd0);
    cyc();

    // Tie after reset: I first, then D, then I again.
    do_reset();
    icache_addr = 16'h1000;
    dcache_addr = 16'h3000;
    icache_req  = 1'b1;
    dcache_req  = 1'b1;
    expect_grant("t2_tie_idle", 1'b0, 1'b0);
    fill("t2_ifill", K_I, 16'h1000, 8, 0);
    expect_grant("t2_gap1", 1'b0, 1'b0);
    fill("t2_dfill", K_D, 16'h3000, 8, 0);
    expect_grant("t2_gap2", 1'b0, 1'b0);
    expect_grant("t2_rr_i", 1'b1, 1'b0);
    icache_req = 1'b0;
    dcache_req = 1'b0;
    expect_grant("t2_abort", 1'b1, 1'b0);
    expect_grant("t2_after", 1'b0, 1'b0);

    // Write priority over a pending I-fill; stray beats ignored.
    dcache_req   = 1'b1;
    dcache_wr    = 1'b1;
    dcache_addr  = 16'h2002;
    dcache_wdata = 16'hBEEF;
    icache_req   = 1'b1;
    icache_addr  = 16'h0400;
    sb_q.push_back('{kind: K_W, addr: 16'h2002, data: 16'hBEEF});
    expect_grant("t3_idle", 1'b0, 1'b0);
    mem_data_valid = 1'b1;
    @(negedge clk);
    check("t3_wr_grant", 64'({icache_grant, dcache_grant}), 64'b01);
    check("t3_wr_strobe", 64'({mem_enable, mem_wr}), 64'b11);
    check("t3_wr_addr", 64'(mem_addr), 64'h2002);
    check("t3_wr_data", 64'(mem_wdata), 64'hBEEF);
    cyc();
    dcache_req = 1'b0;
    dcache_wr  = 1'b0;
    expect_grant("t3_gap", 1'b0, 1'b0);
    mem_data_valid = 1'b0;
    @(negedge clk);
    check("t3_ifill_grant", 64'({icache_grant, dcache_grant}), 64'b10);
    check("t3_ifill_addr", 64'(mem_addr), 64'h0400);
    check("t3_ifill_nowr", 64'({mem_wr, mem_wdata}), 64'd0);
    cyc();
    icache_req = 1'b0;
    expect_grant("t3_abort", 1'b1, 1'b0);
    expect_grant("t3_end", 1'b0, 1'b0);

    // D-fill abort after 3 beats; a fresh fill needs all 8.
    dcache_addr = 16'h5000;
    dcache_req  = 1'b1;
    expect_grant("t4_idle", 1'b0, 1'b0);
    fill("t4_part", K_D, 16'h5000, 3, 1);
    dcache_req = 1'b0;
    expect_grant("t4_drop", 1'b0, 1'b1);
    expect_grant("t4_aborted", 1'b0, 1'b0);
    dcache_req = 1'b1;
    expect_grant("t4_idle2", 1'b0, 1'b0);
    fill("t4_full7", K_D, 16'h5000, 7, 1);
    fill("t4_last", K_D, 16'h5000, 1, 1);
    dcache_req = 1'b0;
    expect_grant("t4_end", 1'b0, 1'b0);

    // Asynchronous reset in the middle of an I-fill.
    icache_addr = 16'h0700;
    icache_req  = 1'b1;
    expect_grant("t5_idle", 1'b0, 1'b0);
    fill("t5_pre", K_I, 16'h0700, 5, 0);
    mem_data_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("t5_async_outs", outs_vec(), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    expect_grant("t5_post_idle", 1'b0, 1'b0);
    mem_data_valid = 1'b0;
    fill("t5_refill7", K_I, 16'h0700, 7, 0);
    expect_grant("t5_hold", 1'b1, 1'b0);
    fill("t5_last", K_I, 16'h0700, 1, 0);
    icache_req = 1'b0;
    expect_grant("t5_end", 1'b0, 1'b0);

    cyc();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
